// File: rtl/dma_src_mc_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dma_src_mc_if                                                 |
// | Purpose  : Shared packet-bus bundle between the multi-channel DMA source |
// |            and the bus arbiter / sink.                                   |
// | Signals  : req     - bus request (source -> arbiter)                     |
// |            grant   - bus grant   (arbiter -> source)                     |
// |            ready   - sink accepts the presented word                     |
// |            valid   - data/pkt_end/ch_id meaningful                       |
// |            data    - current word                                        |
// |            pkt_end - current word is the last of its packet              |
// |            ch_id   - channel whose packet is being sent                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface dma_src_mc_if #(
  parameter int DSIZE = 32,
  parameter int NCH   = 2
);
  localparam int CBITS = $clog2(NCH);

  logic             req;
  logic             grant;
  logic             ready;
  logic             valid;
  logic [DSIZE-1:0] data;
  logic             pkt_end;
  logic [CBITS-1:0] ch_id;

  // Source side
  modport master (
    output req, valid, data, pkt_end, ch_id,
    input  grant, ready
  );

  // Arbiter / sink side
  modport slave (
    input  req, valid, data, pkt_end, ch_id,
    output grant, ready
  );
endinterface
`default_nettype wire

// File: rtl/dma_src_mc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dma_src_mc                                                    |
// | Purpose  : Multi-channel DMA packet source. One packet buffer per        |
// |            channel is filled through a write port; committed packets are |
// |            picked round-robin and streamed onto a shared req/grant bus   |
// |            under ready, with a pkt_end marker on the final word.         |
// | Ports    : p_clk    - clock, rising edge                                 |
// |            rst      - synchronous active-high reset                      |
// |            wr_en/wr_ch/wr_data/wr_last - buffer write port               |
// |            wr_busy  - per channel: packet committed or in flight         |
// |            wr_err   - one-cycle pulse: last write was dropped            |
// |            pkt_done - one-cycle pulse per channel: packet fully sent     |
// |            bus      - packet bus (master modport)                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dma_src_mc #(
  parameter  int DSIZE = 32,
  parameter  int PSIZE = 4,
  parameter  int NCH   = 2,
  localparam int PBITS = $clog2(PSIZE),
  localparam int CBITS = $clog2(NCH)
) (
  input  wire logic             p_clk,
  input  wire logic             rst,
  input  wire logic             wr_en,
  input  wire logic [CBITS-1:0] wr_ch,
  input  wire logic [DSIZE-1:0] wr_data,
  input  wire logic             wr_last,
  output logic      [NCH-1:0]   wr_busy,
  output logic                  wr_err,
  output logic      [NCH-1:0]   pkt_done,
  dma_src_mc_if.master          bus
);

  // Pointers/lengths carry one extra bit so a full PSIZE length fits.
  localparam int               C_WBITS = PBITS + 1;
  localparam logic [C_WBITS-1:0] C_WLAST = C_WBITS'(PSIZE - 1);
  localparam logic [C_WBITS-1:0] C_ONE   = C_WBITS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DSIZE-1:0]     buf_q  [NCH][PSIZE];
  logic [DSIZE-1:0]     buf_d  [NCH][PSIZE];
  logic [C_WBITS-1:0]   wptr_q [NCH];
  logic [C_WBITS-1:0]   wptr_d [NCH];
  logic [C_WBITS-1:0]   len_q  [NCH];
  logic [C_WBITS-1:0]   len_d  [NCH];
  logic [NCH-1:0]       pend_q, pend_d;
  logic [CBITS-1:0]     sel_q, sel_d;
  logic [C_WBITS-1:0]   rd_q, rd_d;
  logic [CBITS-1:0]     last_ch_q, last_ch_d;
  logic                 wr_err_q, wr_err_d;
  logic [NCH-1:0]       pkt_done_q, pkt_done_d;

  logic [NCH-1:0]       wr_hit;
  logic                 rr_found;
  logic [CBITS-1:0]     rr_win;
  logic                 last_word;

  // One-hot accept per channel; a channel index beyond NCH never hits,
  // so out-of-range writes fall through to wr_err.
  always_comb begin
    wr_hit = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_en && (wr_ch == CBITS'(c)) && !pend_q[c]) begin
        wr_hit[c] = 1'b1;
      end
    end
  end

  // Round-robin search starting just after the last channel served.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    for (int i = 1; i <= NCH; i++) begin
      if (!rr_found && pend_q[(int'(last_ch_q) + i) % NCH]) begin
        rr_found = 1'b1;
        rr_win   = CBITS'((int'(last_ch_q) + i) % NCH);
      end
    end
  end

  always_comb begin
    buf_d      = buf_q;
    wptr_d     = wptr_q;
    len_d      = len_q;
    pend_d     = pend_q;
    state_d    = state_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    last_ch_d  = last_ch_q;
    pkt_done_d = '0;
    wr_err_d   = wr_en && !(|wr_hit);
    last_word  = 1'b0;

    bus.req     = 1'b0;
    bus.valid   = 1'b0;
    bus.data    = '0;
    bus.pkt_end = 1'b0;
    bus.ch_id   = '0;

    // Buffer fill; reaching the last slot commits even without wr_last.
    for (int c = 0; c < NCH; c++) begin
      if (wr_hit[c]) begin
        buf_d[c][wptr_q[c][PBITS-1:0]] = wr_data;
        if (wr_last || (wptr_q[c] == C_WLAST)) begin
          len_d[c]  = wptr_q[c] + C_ONE;
          pend_d[c] = 1'b1;
          wptr_d[c] = '0;
        end else begin
          wptr_d[c] = wptr_q[c] + C_ONE;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          sel_d   = rr_win;
          rd_d    = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        bus.req = 1'b1;
        if (bus.grant) begin
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        last_word   = (rd_q == (len_q[sel_q] - C_ONE));
        bus.valid   = 1'b1;
        bus.ch_id   = sel_q;
        bus.data    = buf_q[sel_q][rd_q[PBITS-1:0]];
        bus.pkt_end = last_word;
        // Release the bus in the same cycle the final word is taken.
        bus.req     = !(last_word && bus.ready);
        if (!bus.grant) begin
          // Lost the bus: re-request and resume from the current word.
          state_d = S_REQ;
        end else if (bus.ready) begin
          rd_d = rd_q + C_ONE;
          if (last_word) begin
            pend_d[sel_q]     = 1'b0;
            pkt_done_d[sel_q] = 1'b1;
            last_ch_d         = sel_q;
            state_d           = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Data storage needs no reset: a cleared pend flag makes its content dead.
  always_ff @(posedge p_clk) begin
    buf_q <= buf_d;
  end

  always_ff @(posedge p_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      sel_q      <= '0;
      rd_q       <= '0;
      last_ch_q  <= CBITS'(NCH - 1);
      wr_err_q   <= 1'b0;
      pkt_done_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c] <= '0;
        len_q[c]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      last_ch_q  <= last_ch_d;
      wr_err_q   <= wr_err_d;
      pkt_done_q <= pkt_done_d;
      for (int c = 0; c < NCH; c++) begin
        wptr_q[c] <= wptr_d[c];
        len_q[c]  <= len_d[c];
      end
    end
  end

  assign wr_busy  = pend_q;
  assign wr_err   = wr_err_q;
  assign pkt_done = pkt_done_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_src_mc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dma_src_mc                                                 |
// | Purpose  : Self-checking bench for dma_src_mc. Directed scenarios plus a |
// |            randomized phase; a negedge monitor compares the DUT against  |
// |            a queue-based packet model (per-channel expected packets,     |
// |            round-robin pick, write accept/drop rules).                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dma_src_mc;
  localparam int DSIZE = 32;
  localparam int PSIZE = 4;
  localparam int NCH   = 2;
  localparam int CBITS = $clog2(NCH);

  logic             p_clk   = 1'b0;
  logic             rst     = 1'b1;
  logic             wr_en   = 1'b0;
  logic [CBITS-1:0] wr_ch   = '0;
  logic [DSIZE-1:0] wr_data = '0;
  logic             wr_last = 1'b0;
  logic [NCH-1:0]   wr_busy;
  logic             wr_err;
  logic [NCH-1:0]   pkt_done;

  dma_src_mc_if #(.DSIZE(DSIZE), .NCH(NCH)) bus ();

  dma_src_mc #(.DSIZE(DSIZE), .PSIZE(PSIZE), .NCH(NCH)) dut (
    .p_clk    (p_clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .wr_busy  (wr_busy),
    .wr_err   (wr_err),
    .pkt_done (pkt_done),
    .bus      (bus)
  );

  always #5 p_clk = ~p_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DSIZE-1:0] fill    [NCH][$];
  logic [DSIZE-1:0] exp_pkt [NCH][$];
  bit               m_pend  [NCH];
  bit               bus_free   = 1'b1;
  int               cur_ch     = -1;
  int               m_last     = NCH - 1;
  bit               exp_err    = 1'b0;
  logic [NCH-1:0]   exp_done   = '0;
  bit               after_last = 1'b0;
  bit               exp_req    = 1'b0;
  bit               armed      = 1'b0;
  int               xfer_cnt   = 0;
  int               done_order [$];

  // Everything the DUT will sample at the next rising edge is stable here.
  always @(negedge p_clk) begin
    logic [NCH-1:0] pend_v;
    int             ch;
    int             sz;
    for (int c = 0; c < NCH; c++) pend_v[c] = m_pend[c];

    if (armed) begin
      chk("wr_busy", wr_busy, pend_v);
      chk("wr_err", wr_err, exp_err);
      chk("pkt_done", pkt_done, exp_done);
      if (!bus.valid) chk("idle_outputs", {bus.data, bus.ch_id}, '0);
      if (after_last) chk("gap_after_pkt", {bus.req, bus.valid}, 2'b00);
      if (exp_req) chk("req_rise", bus.req, 1'b1);
      if (bus.valid) begin
        if (cur_ch < 0) begin
          chk("valid_unexpected", bus.valid, 1'b0);
        end else if (exp_pkt[cur_ch].size() == 0) begin
          chk("valid_no_data", bus.valid, 1'b0);
        end else begin
          sz = exp_pkt[cur_ch].size();
          chk("ch_id", bus.ch_id, cur_ch);
          chk("data", bus.data, exp_pkt[cur_ch][0]);
          chk("pkt_end", bus.pkt_end, (sz == 1));
          chk("req_xfer", bus.req, !((sz == 1) && bus.ready));
        end
      end
    end

    exp_err    = 1'b0;
    exp_done   = '0;
    after_last = 1'b0;
    exp_req    = 1'b0;

    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        fill[c].delete();
        exp_pkt[c].delete();
        m_pend[c] = 1'b0;
      end
      cur_ch   = -1;
      bus_free = 1'b1;
      m_last   = NCH - 1;
    end else begin
      if (bus_free && (|pend_v)) begin
        for (int i = 1; i <= NCH; i++) begin
          ch = (m_last + i) % NCH;
          if (m_pend[ch]) begin
            cur_ch = ch;
            break;
          end
        end
        bus_free = 1'b0;
        exp_req  = 1'b1;
      end
      if (bus.valid && bus.grant && bus.ready && cur_ch >= 0 && exp_pkt[cur_ch].size() > 0) begin
        void'(exp_pkt[cur_ch].pop_front());
        xfer_cnt++;
        if (exp_pkt[cur_ch].size() == 0) begin
          m_pend[cur_ch]   = 1'b0;
          exp_done[cur_ch] = 1'b1;
          m_last           = cur_ch;
          done_order.push_back(cur_ch);
          cur_ch     = -1;
          bus_free   = 1'b1;
          after_last = 1'b1;
        end
      end
      if (wr_en) begin
        ch = int'(wr_ch);
        if (ch < NCH && !pend_v[ch]) begin
          fill[ch].push_back(wr_data);
          if (wr_last || fill[ch].size() == PSIZE) begin
            exp_pkt[ch] = fill[ch];
            fill[ch].delete();
            m_pend[ch] = 1'b1;
          end
        end else begin
          exp_err = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge p_clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [DSIZE-1:0] d, input logic last);
    wr_en   = 1'b1;
    wr_ch   = CBITS'(ch);
    wr_data = d;
    wr_last = last;
    step();
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic wr_when_free(input int ch, input logic [DSIZE-1:0] d, input logic last);
    int n = 0;
    while (wr_busy[ch] && n < 100) begin step(); n++; end
    chk("wait_free_timeout", (n < 100), 1'b1);
    wr(ch, d, last);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.valid && n < 50) begin step(); n++; end
    chk("wait_valid_timeout", (n < 50), 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    wr_en = 1'b0; rst = 1'b0; bus.grant = 1'b1; bus.ready = 1'b1;
    step();
    while ((wr_busy != '0 || bus.valid || bus.req) && n < 200) begin step(); n++; end
    chk("drain_timeout", (n < 200), 1'b1);
    step();
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bus.grant = 1'b0;
    bus.ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    armed = 1'b1;
    step();
    rst = 1'b0;

    // 1: three-word packet on ch0, full rate
    bus.grant = 1'b1; bus.ready = 1'b1;
    wr(0, 32'hA000_0000, 1'b0);
    wr(0, 32'hA000_0001, 1'b0);
    wr(0, 32'hA000_0002, 1'b1);
    @(negedge p_clk); chk("t1_req_lat0", bus.req, 1'b0); chk("t1_busy", wr_busy, 2'b01);
    @(negedge p_clk); chk("t1_req_lat1", {bus.req, bus.valid}, 2'b10);
    @(negedge p_clk); chk("t1_w0", {bus.valid, bus.pkt_end, bus.data}, {2'b10, 32'hA000_0000});
    @(negedge p_clk); chk("t1_w1", {bus.valid, bus.pkt_end, bus.data}, {2'b10, 32'hA000_0001});
    @(negedge p_clk); chk("t1_w2", {bus.valid, bus.pkt_end, bus.req, bus.data}, {3'b110, 32'hA000_0002});
    @(negedge p_clk); chk("t1_done", {pkt_done, bus.req, bus.valid}, {2'b01, 2'b00});
    step();

    // 2: ch1 auto-commit at PSIZE words, fifth write dropped
    bus.grant = 1'b0;
    for (int i = 0; i < PSIZE; i++) wr(1, 32'hB100_0000 + i, 1'b0);
    @(negedge p_clk); chk("t2_busy", wr_busy, 2'b10);
    step();
    wr(1, 32'hDEAD_BEEF, 1'b0);
    @(negedge p_clk); chk("t2_err_pulse", wr_err, 1'b1);
    @(negedge p_clk); chk("t2_err_clear", wr_err, 1'b0);
    step();
    drain();

    // 3: round-robin order ch0, ch1, ch0, ch1 after reset
    rst = 1'b1; step(); rst = 1'b0;
    done_order.delete();
    bus.grant = 1'b0;
    wr(0, 32'hC000_0000, 1'b0); wr(0, 32'hC000_0001, 1'b1);
    wr(1, 32'hC100_0000, 1'b0); wr(1, 32'hC100_0001, 1'b1);
    bus.grant = 1'b1; bus.ready = 1'b1;
    wr_when_free(0, 32'hC000_0010, 1'b0); wr_when_free(0, 32'hC000_0011, 1'b1);
    wr_when_free(1, 32'hC100_0010, 1'b0); wr_when_free(1, 32'hC100_0011, 1'b1);
    drain();
    chk("t3_order_len", done_order.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < done_order.size()) chk("t3_order", done_order[i], i % 2);
    end

    // 4: ready toggling during a 4-word packet
    xfer_cnt = 0;
    for (int i = 0; i < 4; i++) wr(0, 32'hD000_0000 + i, (i == 3));
    begin
      int n = 0;
      while (wr_busy[0] && n < 60) begin bus.ready = ~bus.ready; step(); n++; end
      chk("t4_timeout", (n < 60), 1'b1);
    end
    drain();
    chk("t4_xfers", xfer_cnt, 4);

    // 5: grant dropped after first word, resume without replay
    xfer_cnt = 0;
    wr(1, 32'hE100_0000, 1'b0); wr(1, 32'hE100_0001, 1'b0); wr(1, 32'hE100_0002, 1'b1);
    wait_valid();
    step();
    bus.grant = 1'b0;
    @(negedge p_clk); chk("t5_hold_valid", bus.valid, 1'b1);
    step();
    @(negedge p_clk); chk("t5_back_to_req", {bus.valid, bus.req}, 2'b01);
    step();
    drain();
    chk("t5_xfers", xfer_cnt, 3);

    // 6: reset in the middle of a transfer
    for (int i = 0; i < 4; i++) wr(1, 32'hF100_0000 + i, (i == 3));
    wait_valid();
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge p_clk); chk("t6_after_rst", {bus.req, bus.valid, wr_busy}, '0);
    step();
    xfer_cnt = 0;
    done_order.delete();
    wr(0, 32'hF000_0000, 1'b0); wr(0, 32'hF000_0001, 1'b1);
    drain();
    chk("t6_xfers", xfer_cnt, 2);
    chk("t6_done_cnt", done_order.size(), 1);
    if (done_order.size() > 0) chk("t6_done_ch", done_order[0], 0);

    // 7: write during the final-word cycle is dropped, next cycle accepted
    wr(0, 32'h7000_0000, 1'b0); wr(0, 32'h7000_0001, 1'b1);
    begin
      int n = 0;
      while (!(bus.valid && bus.pkt_end) && n < 50) begin step(); n++; end
      chk("t7_timeout", (n < 50), 1'b1);
    end
    wr_en = 1'b1; wr_ch = 1'b0; wr_data = 32'h7000_00FF; wr_last = 1'b1;
    step();
    @(negedge p_clk); chk("t7_drop", wr_err, 1'b1);
    step();
    wr_en = 1'b0; wr_last = 1'b0;
    @(negedge p_clk); chk("t7_accept", {wr_err, wr_busy[0]}, 2'b01);
    step();
    drain();

    // 8: randomized traffic
    for (int k = 0; k < 1500; k++) begin
      rst       = ($urandom_range(0, 299) == 0);
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_ch     = CBITS'($urandom_range(0, NCH - 1));
      wr_data   = $urandom;
      wr_last   = ($urandom_range(0, 3) == 0);
      bus.grant = ($urandom_range(0, 9) != 0);
      bus.ready = ($urandom_range(0, 9) < 7);
      step();
    end
    wr_last = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
